// File: rtl/vga_frame_scanner.sv
// 160x120x3 frame buffer: plot writes in, raster scan out with sync/blank/frame-start.
// The scan runs through a 3-stage pipeline: counters, read address, output registers.
module vga_frame_scanner #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int H_TOTAL         = 200,
  parameter int H_SYNC_START    = 168,
  parameter int H_SYNC_END      = 184,
  parameter int V_TOTAL         = 130,
  parameter int V_SYNC_START    = 122,
  parameter int V_SYNC_END      = 124,
  parameter int PIX_DIV         = 1
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [2:0] iColour,
  input  logic       iPlot,
  output logic [2:0] oScanColour,
  output logic       oHSync,
  output logic       oVSync,
  output logic       oBlank,
  output logic       oFrameStart,
  output logic       oDropped
);
  localparam int MEM_DEPTH = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [2:0] mem_q [MEM_DEPTH];

  // write path
  logic          in_range, wr_en;
  logic [AW-1:0] wr_addr;

  assign in_range = (int'(iX) < X_SCREEN_PIXELS) && (int'(iY) < Y_SCREEN_PIXELS);
  assign wr_en    = iResetn && iPlot && in_range;
  assign wr_addr  = AW'(iY) * AW'(X_SCREEN_PIXELS) + AW'(iX);

  always_ff @(posedge iClock) begin
    if (wr_en) mem_q[wr_addr] <= iColour;
  end

  // stage 0: divider and raster counters
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          wrap_q, wrap_d;
  logic          tick;

  // stage-1 next values derived from stage 0
  logic [AW-1:0] addr1_q, addr1_d;
  logic          vis1_q, vis1_d;
  logic          hs1_q, hs1_d;
  logic          vs1_q, vs1_d;
  logic          fs1_q;

  assign tick = (div_q == DW'(PIX_DIV - 1));

  always_comb begin
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    wrap_d = 1'b0;
    if (tick) begin
      div_d = '0;
      // wrap_q marks the first clock of pixel (0,0) after a real frame wrap
      wrap_d = (h_q == HW'(H_TOTAL - 1)) && (v_q == VW'(V_TOTAL - 1));
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end

    vis1_d  = (int'(h_q) < X_SCREEN_PIXELS) && (int'(v_q) < Y_SCREEN_PIXELS);
    addr1_d = vis1_d ? AW'(v_q) * AW'(X_SCREEN_PIXELS) + AW'(h_q) : '0;
    hs1_d   = !((int'(h_q) >= H_SYNC_START) && (int'(h_q) < H_SYNC_END));
    vs1_d   = !((int'(v_q) >= V_SYNC_START) && (int'(v_q) < V_SYNC_END));
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      wrap_q <= wrap_d;
    end
  end

  // stage 1
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      addr1_q <= '0;
      vis1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      fs1_q   <= 1'b0;
    end else begin
      addr1_q <= addr1_d;
      vis1_q  <= vis1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= wrap_q;
    end
  end

  // stage 2: the read happens here, so a write on the same edge is not seen (read-first)
  logic [2:0] scan_q;
  logic       hs2_q, vs2_q, blank_q, fs2_q, drop_q;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      scan_q  <= '0;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      blank_q <= 1'b1;
      fs2_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      scan_q  <= vis1_q ? mem_q[addr1_q] : 3'd0;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      blank_q <= !vis1_q;
      fs2_q   <= fs1_q;
      drop_q  <= iPlot && !in_range;
    end
  end

  assign oScanColour = scan_q;
  assign oHSync      = hs2_q;
  assign oVSync      = vs2_q;
  assign oBlank      = blank_q;
  assign oFrameStart = fs2_q;
  assign oDropped    = drop_q;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: two instances (PIX_DIV=1 and PIX_DIV=2) against a
// cycle-count-based raster model, plus hand-computed literal expectations.
module tb_vga_frame_scanner;
  logic       clk = 1'b0;
  logic [1:0] rstn = 2'b11;
  logic [7:0] ix;
  logic [6:0] iy;
  logic [2:0] col;
  logic       plot;

  logic [1:0][2:0] sc;
  logic [1:0]      hs, vs, bl, fs, dr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_frame_scanner #(.PIX_DIV(1)) dut0 (
    .iClock(clk), .iResetn(rstn[0]), .iX(ix), .iY(iy), .iColour(col), .iPlot(plot),
    .oScanColour(sc[0]), .oHSync(hs[0]), .oVSync(vs[0]), .oBlank(bl[0]),
    .oFrameStart(fs[0]), .oDropped(dr[0]));

  vga_frame_scanner #(.PIX_DIV(2)) dut1 (
    .iClock(clk), .iResetn(rstn[1]), .iX(ix), .iY(iy), .iColour(col), .iPlot(plot),
    .oScanColour(sc[1]), .oHSync(hs[1]), .oVSync(vs[1]), .oBlank(bl[1]),
    .oFrameStart(fs[1]), .oDropped(dr[1]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int x, input int y, input int c);
    ix   = 8'(x);
    iy   = 7'(y);
    col  = 3'(c);
    plot = 1'b1;
  endtask

  // model: per-DUT memory image and count of edges since reset release
  logic [2:0] mm [2][19200];
  int         k [2];
  int         divs [2];
  logic [2:0] e_sc [2];
  logic       e_hs [2], e_vs [2], e_bl [2], e_fs [2], e_dr [2];

  // measurements on the PIX_DIV=1 instance
  int hs_low_l0 = 0, bl_low_l0 = 0, vs_low_f1 = 0, fs_cnt = 0;
  int fs_t [2];

  initial begin : model_and_compare
    int j, p, h, v;
    logic inr;
    divs[0] = 1;
    divs[1] = 2;
    for (int d = 0; d < 2; d++) begin
      k[d] = 0;
      for (int a = 0; a < 19200; a++) mm[d][a] = 3'd0;
    end
    forever begin
      @(posedge clk);
      inr = (int'(ix) < 160) && (int'(iy) < 120);
      for (int d = 0; d < 2; d++) begin
        e_sc[d] = 3'd0; e_hs[d] = 1'b1; e_vs[d] = 1'b1;
        e_bl[d] = 1'b1; e_fs[d] = 1'b0; e_dr[d] = 1'b0;
        if (!rstn[d]) begin
          k[d] = 0;
        end else begin
          k[d]++;
          e_dr[d] = plot && !inr;
          if (k[d] >= 2) begin
            j = k[d] - 2;
            p = j / divs[d];
            h = p % 200;
            v = (p / 200) % 130;
            e_bl[d] = !(h < 160 && v < 120);
            e_sc[d] = e_bl[d] ? 3'd0 : mm[d][v * 160 + h];
            e_hs[d] = !(h >= 168 && h < 184);
            e_vs[d] = !(v >= 122 && v < 124);
            e_fs[d] = (j % divs[d] == 0) && (p > 0) && (p % 26000 == 0);
          end
          // memory image updated after the expectation: same-edge writes are not visible
          if (plot && inr) mm[d][int'(iy) * 160 + int'(ix)] = col;
        end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d colour k=%0d", d, k[d]), int'(sc[d]), int'(e_sc[d]));
        chk($sformatf("d%0d hsync k=%0d", d, k[d]), int'(hs[d]), int'(e_hs[d]));
        chk($sformatf("d%0d vsync k=%0d", d, k[d]), int'(vs[d]), int'(e_vs[d]));
        chk($sformatf("d%0d blank k=%0d", d, k[d]), int'(bl[d]), int'(e_bl[d]));
        chk($sformatf("d%0d fstart k=%0d", d, k[d]), int'(fs[d]), int'(e_fs[d]));
        chk($sformatf("d%0d dropped k=%0d", d, k[d]), int'(dr[d]), int'(e_dr[d]));
      end

      // literal expectations, PIX_DIV=1
      if (rstn[0]) begin
        case (k[0])
          1:     chk("blank 1 clk after release", int'(bl[0]), 1);
          2: begin
                 chk("blank 2 clk after release", int'(bl[0]), 0);
                 chk("pixel(0,0)", int'(sc[0]), 3);
               end
          3:     chk("pixel(1,0) written 1 clk before read", int'(sc[0]), 5);
          4:     chk("drop x=160", int'(dr[0]), 1);
          5:     chk("drop y=120", int'(dr[0]), 1);
          6:     chk("no drop (159,119)", int'(dr[0]), 0);
          12:    chk("collision old colour", int'(sc[0]), 2);
          22:    chk("pixel(20,0) frame0", int'(sc[0]), 0);
          202:   chk("pixel(0,1) untouched by x=160", int'(sc[0]), 0);
          606:   chk("pixel(4,3)", int'(sc[0]), 0);
          607:   chk("pixel(5,3)", int'(sc[0]), 6);
          608:   chk("pixel(6,3)", int'(sc[0]), 0);
          23961: chk("pixel(159,119)", int'(sc[0]), 4);
          26012: chk("collision new colour", int'(sc[0]), 7);
          26022: chk("pixel(20,0) frame1", int'(sc[0]), 3);
          default: ;
        endcase
        if (k[0] >= 2 && k[0] < 202) begin
          if (!hs[0]) hs_low_l0++;
          if (!bl[0]) bl_low_l0++;
        end
        if (k[0] >= 26002 && k[0] < 52002 && !vs[0]) vs_low_f1++;
        if (fs[0]) begin
          if (fs_cnt < 2) fs_t[fs_cnt] = k[0];
          fs_cnt++;
        end
      end

      // literal expectations, PIX_DIV=2 (also after the mid-frame reset)
      if (rstn[1]) begin
        case (k[1])
          1:       chk("d1 blank 1 clk after release", int'(bl[1]), 1);
          2: begin
                   chk("d1 blank 2 clk after release", int'(bl[1]), 0);
                   chk("d1 pixel(0,0) first clk", int'(sc[1]), 3);
                 end
          3:       chk("d1 pixel(0,0) held", int'(sc[1]), 3);
          4:       chk("d1 pixel(1,0)", int'(sc[1]), 5);
          5:       chk("d1 pixel(1,0) held", int'(sc[1]), 5);
          default: ;
        endcase
      end
    end
  end

  initial begin : stim
    plot = 1'b0; ix = '0; iy = '0; col = '0;
    #2 rstn = 2'b00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset colour", d), int'(sc[d]), 0);
      chk($sformatf("d%0d reset hsync", d), int'(hs[d]), 1);
      chk($sformatf("d%0d reset vsync", d), int'(vs[d]), 1);
      chk($sformatf("d%0d reset blank", d), int'(bl[d]), 1);
      chk($sformatf("d%0d reset fstart", d), int'(fs[d]), 0);
      chk($sformatf("d%0d reset dropped", d), int'(dr[d]), 0);
    end
    // iteration c sets up the inputs sampled by edge c after release
    for (int c = 1; c <= 52010; c++) begin
      plot = 1'b0; ix = '0; iy = '0; col = '0;
      if (c == 1) rstn = 2'b11;
      case (c)
        1:     drive(0, 0, 3);
        2:     drive(1, 0, 5);
        3:     drive(10, 0, 2);
        4:     drive(160, 0, 5);
        5:     drive(0, 120, 5);
        6:     drive(159, 119, 4);
        7:     drive(5, 3, 6);
        12:    drive(10, 0, 7);
        20011: drive(200, 0, 1);
        20012: drive(20, 0, 3);
        default: ;
      endcase
      if (c == 20010) rstn[1] = 1'b0;
      if (c == 20013) rstn[1] = 1'b1;
      @(negedge clk);
    end
    chk("hsync low clocks in line", hs_low_l0, 16);
    chk("blank low clocks in line", bl_low_l0, 160);
    chk("vsync low clocks in frame", vs_low_f1, 400);
    chk("frame start count", fs_cnt, 2);
    if (fs_cnt >= 2) begin
      chk("first frame start", fs_t[0], 26002);
      chk("frame start spacing", fs_t[1] - fs_t[0], 26000);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_frame_scanner.md
# vga_frame_scanner

Receiving end of the pixel-plot interface driven by the box-drawing FSM. It accepts one plot request per clock (x, y, colour, plot strobe) into an on-chip 160x120x3 frame buffer, and independently scans the buffer out in raster order with horizontal/vertical sync, blanking and a frame-start marker for the display side. The write and scan paths share one clock. Writes never stall: the drawing FSM has no back-pressure.

## Interface
- X_SCREEN_PIXELS, 160, visible columns; valid x is 0..159
- Y_SCREEN_PIXELS, 120, visible rows; valid y is 0..119
- H_TOTAL, 200, pixel ticks per line
- H_SYNC_START, 168, first h count with oHSync low
- H_SYNC_END, 184, first h count after the sync pulse
- V_TOTAL, 130, lines per frame
- V_SYNC_START, 122, first line with oVSync low
- V_SYNC_END, 124, first line after the sync pulse
- PIX_DIV, 1, clocks per pixel tick (≥1)
- iClock  in  1  single clock
- iResetn  in  1  asynchronous, active-low reset
- iX  in  8  plot x coordinate
- iY  in  7  plot y coordinate
- iColour  in  3  plot colour
- iPlot  in  1  write strobe, sampled each rising edge
- oScanColour  out  3  scanned pixel colour; 0 while blanking
- oHSync  out  1  horizontal sync, active low
- oVSync  out  1  vertical sync, active low
- oBlank  out  1  high outside the visible area
- oFrameStart  out  1  one-clock pulse on the first pixel of each frame
- oDropped  out  1  one-clock pulse for a rejected plot

## Operation
- Memory: 19200 x 3, simple dual-port. Address = y*X_SCREEN_PIXELS + x (15 bits, unsigned; multiply done at full width, no truncation). Contents are not cleared by reset; simulation initialises them to 0.
- Write path: iPlot=1 with x<160 and y<120 writes iColour at the edge. If either coordinate is out of range, there is no write and oDropped=1 on the next cycle. Back-to-back plots are accepted every clock.
- Divider: counts 0..PIX_DIV-1. A tick occurs when it equals PIX_DIV-1.
- Counters: h counts 0..H_TOTAL-1, v counts 0..V_TOTAL-1, advancing on a tick only. When h wraps, v increments. When v wraps too, both go to 0 (frame wrap).
- Pipeline:
  - Stage 0: the counters.
  - Stage 1: registered read address plus registered h/v copies.
  - Stage 2: output registers.
  - Outputs therefore reflect the counter state from exactly 2 clocks earlier, independent of PIX_DIV.
- Visible means h<X_SCREEN_PIXELS and v<Y_SCREEN_PIXELS.
  - oBlank = !visible.
  - oScanColour = mem[v*160+h] if visible, else 0.
- Sync: oHSync=0 when H_SYNC_START≤h<H_SYNC_END. oVSync=0 when V_SYNC_START≤v<V_SYNC_END. Both are evaluated on the stage-0 values and delayed to stage 2.
- oFrameStart: asserts for 1 clock, 2 clocks after a tick that causes a frame wrap. It does not assert after reset release.
- Same-address collision: the read returns the old data (read-first). The new colour appears on the next scan of that pixel.

## Timing
- Reset (async assert, synchronous-release behaviour):
  - Divider, h and v go to 0.
  - Pipeline registers are cleared: oScanColour=0, oHSync=1, oVSync=1, oBlank=1, oFrameStart=0, oDropped=0.
- After release with PIX_DIV=1:
  - Counter (0,0) is in the first cycle; the pixel-(0,0) colour appears on outputs 2 clocks later.
  - Then one new pixel per clock follows.
- Write-to-memory latency is 1 clock. A scan read issued ≥1 clock after the write edge sees the new data.
- Reset mid-frame: the scan restarts at (0,0) and any in-flight pipeline data is discarded. A plot presented during reset is ignored and oDropped stays 0.
- Line length is H_TOTAL*PIX_DIV clocks. Frame length is H_TOTAL*V_TOTAL*PIX_DIV clocks (26000 at defaults).

## Test plan
- Reset: hold iResetn=0 -> oHSync=1, oVSync=1, oBlank=1, oScanColour=0, oFrameStart=0, oDropped=0. Release -> oBlank=0 exactly 2 clocks later.
- Plot then scan: plot (x=5, y=3, colour=6). Over the next frame, oScanColour=6 exactly on the output cycle for h=5, v=3, with neighbouring pixels unchanged.
- Rejected plots:
  - Plot x=160, y=0 -> oDropped=1 one clock later, no memory change.
  - Plot x=0, y=120 -> same.
  - Plot x=159, y=119 -> written, no drop.
- Sync and frame timing at defaults:
  - oHSync is low for 16 consecutive clocks per 200-clock line.
  - oVSync is low for 400 clocks per frame.
  - oFrameStart pulses are 26000 clocks apart.
  - oBlank is low for 160 clocks per visible line.
- Collision: plot colour 7 to pixel (10,0) on the same edge its scan read is issued -> the old colour is output this frame, 7 on the next frame.
- Reset mid-frame with PIX_DIV=2: assert reset at v=50 -> outputs return to reset values. After release, pixel (0,0) appears 2 clocks later and each pixel is held 2 clocks.
